// File: rtl/imm_extender_pkg.sv
// Shared RV32I decode definitions: immediate format encoding and datapath width.
// Used by the immediate generator and the control decoder so both agree on immsrc.
// Pure declarations, no logic state.
package imm_extender_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } immsrc_e;

  // Encodings above IMM_U are reserved and flagged as illegal.
  function automatic logic imm_sel_illegal(input logic [2:0] sel);
    return (sel > IMM_U);
  endfunction

endpackage

// File: rtl/imm_extender.sv
// RV32I immediate generator: gathers and extends the immediate from instr[31:7].
// Latency: 0 cycles to immext/illegal, 1 cycle to immext_q/illegal_q.
// No handshake; the output register loads whenever en is high and holds otherwise.
module imm_extender
  import imm_extender_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:7]     instr,
  input  logic [2:0]      immsrc,
  input  logic            en,
  output logic [XLEN-1:0] immext,
  output logic [XLEN-1:0] immext_q,
  output logic            illegal,
  output logic            illegal_q
);

  logic [XLEN-1:0] w_immext;
  logic            w_illegal;
  logic [XLEN-1:0] r_immext_q;
  logic            r_illegal_q;

  // Select the immediate layout; sign always comes from instr[31], U zero-fills.
  always_comb begin
    w_immext  = '0;
    w_illegal = 1'b0;
    case (immsrc)
      IMM_I:   w_immext = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   w_immext = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   w_immext = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:   w_immext = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_U:   w_immext = {instr[31:12], 12'b0};
      default: begin
        w_immext  = '0;
        w_illegal = imm_sel_illegal(immsrc);
      end
    endcase
  end

  // Pipeline-boundary copy: async clear, load on en, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_immext_q  <= '0;
      r_illegal_q <= 1'b0;
    end else if (en) begin
      r_immext_q  <= w_immext;
      r_illegal_q <= w_illegal;
    end
  end

  assign immext    = w_immext;
  assign illegal   = w_illegal;
  assign immext_q  = r_immext_q;
  assign illegal_q = r_illegal_q;

endmodule

// File: tb/tb_imm_extender.sv
// Self-checking bench for imm_extender: directed vectors, randomized format sweeps
// against an arithmetic reference model, and output-register reset/enable behaviour.
// Inputs change on the falling edge; outputs are sampled 1 time unit after changes/edges.
module tb_imm_extender;

  logic        clk;
  logic        rst_n;
  logic [31:7] instr;
  logic [2:0]  immsrc;
  logic        en;
  logic [31:0] immext;
  logic [31:0] immext_q;
  logic        illegal;
  logic        illegal_q;

  int n_checks = 0;
  int n_errors = 0;

  imm_extender dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .instr     (instr),
    .immsrc    (immsrc),
    .en        (en),
    .immext    (immext),
    .immext_q  (immext_q),
    .illegal   (illegal),
    .illegal_q (illegal_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: immediate value as a signed integer from the ISA bit-field weights.
  function automatic logic [31:0] ref_imm(input logic [31:0] w, input int sel);
    longint v;
    v = 0;
    case (sel)
      0: begin
        v = longint'(w[31:20]);
        if (w[31]) v = v - 4096;
      end
      1: begin
        v = longint'(w[31:25]) * 32 + longint'(w[11:7]);
        if (w[31]) v = v - 4096;
      end
      2: begin
        v = longint'(w[31]) * 4096 + longint'(w[7]) * 2048
          + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
        if (w[31]) v = v - 8192;
      end
      3: begin
        v = longint'(w[31]) * 1048576 + longint'(w[19:12]) * 4096
          + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2;
        if (w[31]) v = v - 2097152;
      end
      4: v = longint'(w[31:12]) * 4096;
      default: v = 0;
    endcase
    return v[31:0];
  endfunction

  // Bits each format ignores (within instr[31:7]).
  function automatic logic [31:0] unused_mask(input int sel);
    case (sel)
      0:       return 32'h000F_FF80;  // [19:7]
      1, 2:    return 32'h01FF_F000;  // [24:12]
      3, 4:    return 32'h0000_0F80;  // [11:7]
      default: return 32'h0;
    endcase
  endfunction

  task automatic drive(input logic [31:0] w, input int sel);
    instr  = w[31:7];
    immsrc = sel[2:0];
  endtask

  task automatic comb_vec(input string tag, input logic [31:0] w, input int sel,
                          input logic [31:0] exp);
    drive(w, sel);
    #1;
    chk(tag, immext, exp);
  endtask

  logic [31:0] w;
  logic [31:0] exp_v;
  logic [31:0] m_q;
  logic        m_ill_q;
  int          sel;

  initial begin
    rst_n  = 1'b0;
    en     = 1'b0;
    instr  = '0;
    immsrc = 3'b000;
    #3;
    chk("reset_immext_q", immext_q, 32'h0);
    chk("reset_illegal_q", {31'b0, illegal_q}, 32'h0);

    // I-type boundaries
    comb_vec("I_004", {12'h004, 20'h0}, 0, 32'h0000_0004);
    comb_vec("I_FFC", {12'hFFC, 20'h0}, 0, 32'hFFFF_FFFC);
    comb_vec("I_7FF", {12'h7FF, 20'h0}, 0, 32'h0000_07FF);
    comb_vec("I_800", {12'h800, 20'h0}, 0, 32'hFFFF_F800);
    comb_vec("I_FFF", {12'hFFF, 20'h0}, 0, 32'hFFFF_FFFF);
    chk("I_legal", {31'b0, illegal}, 32'h0);

    // S / B
    comb_vec("S_pos", {7'b0000000, 5'b0, 5'b0, 3'b0, 5'b00100, 7'b0}, 1, 32'h0000_0004);
    comb_vec("S_neg", {7'b1111111, 5'b0, 5'b0, 3'b0, 5'b00100, 7'b0}, 1, 32'hFFFF_FFE4);
    comb_vec("B_neg", {1'b1, 6'b111111, 5'b0, 5'b0, 3'b0, 4'b0010, 1'b0, 7'b0}, 2,
             32'hFFFF_F7E4);
    comb_vec("B_bit7_to_11", {1'b0, 6'b0, 5'b0, 5'b0, 3'b0, 4'b0000, 1'b1, 7'b0}, 2,
             32'h0000_0800);
    comb_vec("B_bit0_zero", {25'h1FF_FFFF, 7'b0}, 2, 32'hFFFF_FFFE);

    // J
    comb_vec("J_pos", {1'b0, 10'b0000000100, 1'b1, 8'b00110000, 5'b0, 7'b0}, 3,
             32'h0003_0808);
    comb_vec("J_neg", {1'b1, 10'b1111111100, 1'b1, 8'b00011100, 5'b0, 7'b0}, 3,
             32'hFFF1_CFF8);

    // U, with and without rd bits set
    comb_vec("U_00100", {20'h00100, 12'h0}, 4, 32'h0010_0000);
    comb_vec("U_FFF00", {20'hFFF00, 12'h0}, 4, 32'hFFF0_0000);
    comb_vec("U_00100_rd", {20'h00100, 5'b11111, 7'h0}, 4, 32'h0010_0000);
    comb_vec("U_FFF00_rd", {20'hFFF00, 5'b11111, 7'h0}, 4, 32'hFFF0_0000);

    // Illegal selectors
    for (int s = 5; s < 8; s++) begin
      comb_vec($sformatf("ILL_%0d_imm", s), 32'hFFFF_FFFF, s, 32'h0);
      chk($sformatf("ILL_%0d_flag", s), {31'b0, illegal}, 32'h1);
    end

    // Random sweep against the model
    for (int k = 0; k < 300; k++) begin
      w   = $urandom & 32'hFFFF_FF80;
      sel = $urandom_range(0, 7);
      drive(w, sel);
      #1;
      chk($sformatf("rand_imm_sel%0d", sel), immext, ref_imm(w, sel));
      chk($sformatf("rand_ill_sel%0d", sel), {31'b0, illegal}, {31'b0, (sel > 4)});
    end

    // Unused-bit sweep per legal format
    for (int s = 0; s < 5; s++) begin
      w     = $urandom & 32'hFFFF_FF80;
      exp_v = ref_imm(w, s);
      for (int k = 0; k < 20; k++) begin
        drive((w & ~unused_mask(s)) | ($urandom & unused_mask(s)), s);
        #1;
        chk($sformatf("unused_sel%0d", s), immext, exp_v);
      end
    end

    // Register: release reset between edges, load I 0xFFC
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    drive({12'hFFC, 20'h0}, 0);
    @(posedge clk); #1;
    chk("reg_load_FFC", immext_q, 32'hFFFF_FFFC);
    chk("reg_load_ill", {31'b0, illegal_q}, 32'h0);

    // Hold with en low while the input changes
    @(negedge clk);
    en = 1'b0;
    drive(32'hFFFF_FFFF, 6);
    @(posedge clk); #1;
    chk("reg_hold_imm", immext_q, 32'hFFFF_FFFC);
    chk("reg_hold_ill", {31'b0, illegal_q}, 32'h0);

    // Load an illegal selector
    @(negedge clk);
    en = 1'b1;
    @(posedge clk); #1;
    chk("reg_ill_imm", immext_q, 32'h0);
    chk("reg_ill_flag", {31'b0, illegal_q}, 32'h1);

    // Load a J value, then assert reset mid-cycle
    @(negedge clk);
    drive({1'b1, 10'b1111111100, 1'b1, 8'b00011100, 5'b0, 7'b0}, 3);
    @(posedge clk); #1;
    chk("reg_load_J", immext_q, 32'hFFF1_CFF8);
    #1;
    rst_n = 1'b0;
    #1;
    chk("reg_async_imm", immext_q, 32'h0);
    chk("reg_async_ill", {31'b0, illegal_q}, 32'h0);
    @(posedge clk); #1;
    chk("reg_in_reset", immext_q, 32'h0);

    // After release: en low edge keeps zero, first en-high edge loads
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b0;
    @(posedge clk); #1;
    chk("reg_post_rst_hold", immext_q, 32'h0);
    @(negedge clk);
    en = 1'b1;
    @(posedge clk); #1;
    chk("reg_post_rst_load", immext_q, 32'hFFF1_CFF8);

    // Randomized enable/data against a register model
    m_q     = 32'hFFF1_CFF8;
    m_ill_q = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      w   = $urandom & 32'hFFFF_FF80;
      sel = $urandom_range(0, 7);
      en  = 1'($urandom_range(0, 1));
      drive(w, sel);
      if (en) begin
        m_q     = ref_imm(w, sel);
        m_ill_q = (sel > 4);
      end
      @(posedge clk); #1;
      chk("reg_rand_imm", immext_q, m_q);
      chk("reg_rand_ill", {31'b0, illegal_q}, {31'b0, m_ill_q});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/imm_extender.md
# imm_extender

- Combinational RV32I immediate generator for the decode stage.
- Gathers immediate bits from instruction bits [31:7] according to a 3-bit format selector, then sign-extends (I/S/B/J) or zero-fills (U) to 32 bits.
- Also provides a registered copy of the result and an illegal-selector flag for the decode/execute pipeline boundary.

## Interface
Parameters: none.
- clk  input  1  clock. One clock domain; only the registered outputs use it.
- rst_n  input  1  asynchronous active-low reset.
- instr  input  25  instruction bits [31:7], declared as [31:7] so bit indices match the ISA.
- immsrc  input  3  format select: 000 I, 001 S, 010 B, 011 J, 100 U, 101–111 illegal.
- en  input  1  load enable for the registered outputs.
- immext  output  32  combinational extended immediate.
- immext_q  output  32  registered immext.
- illegal  output  1  combinational; 1 when immsrc is 101–111.
- illegal_q  output  1  registered illegal.

## Operation
Immediate formats (i = instr, s = i[31]):
- I (000): {20×s, i[31:20]}
- S (001): {20×s, i[31:25], i[11:7]}
- B (010): {20×s, i[7], i[30:25], i[11:8], 0}. Bit 0 is always 0.
- J (011): {12×s, i[19:12], i[20], i[30:21], 0}. Bit 0 is always 0.
- U (100): {i[31:12], 12×0}. No extension.
- 101–111: immext = 0 and illegal = 1.

Rules:
- immext and illegal are pure functions of instr and immsrc: no latches, no X propagation.
- For every legal format, sign-extension uses i[31] only.
- Bits of instr that a format does not use must not affect immext.

## Timing
- immext and illegal: zero-cycle combinational; they settle within the same cycle as input changes.
- immext_q and illegal_q:
  - Reset: asynchronous, to 0 / 0, whenever rst_n is low, independent of clk.
  - After reset, on each rising clk edge with en = 1: load the current immext and illegal.
  - en = 0: hold.
  - Reset asserted mid-operation: clears the registers immediately. The first load after deassertion occurs on the first clk edge with en = 1.
- Latency: 0 cycles to immext, 1 cycle to immext_q.
- There is no handshake.

## Structure
- Shared package (e.g. riscv_pkg):
  - immsrc encoding as an enum with IMM_I=3'b000, IMM_S=3'b001, IMM_B=3'b010, IMM_J=3'b011, IMM_U=3'b100.
  - XLEN=32.
- The control decoder imports the same package.
- RTL body: one always_comb case on immsrc plus one always_ff output register.
- No sub-module is required. If desired, the register may be factored as a generic enabled flop with asynchronous active-low reset (dff_en_rn).

## Test plan
Test plan (instr shown MSB-first as 25 bits):
- I-type:
  - imm field 0x004 -> 0x00000004
  - 0xFFC -> 0xFFFFFFFC
  - 0x7FF -> 0x000007FF
  - 0x800 -> 0xFFFFF800
  - 0xFFF -> 0xFFFFFFFF
- S/B:
  - S, instr 0000000_00000_00000_000_00100 -> 0x00000004.
  - S, instr 1111111_…_00100 -> 0xFFFFFFE4.
  - B, instr 1_111111_00000_00000_000_0010_0 -> 0xFFFFF7E4.
  - Checks: i[7] lands in bit 11; bit 0 = 0.
- J:
  - instr 0_0000000100_1_00110000_00000 -> 0x00030808.
  - instr 1_1111111100_1_00011100_00000 -> 0xFFF1CFF8.
- U:
  - instr[31:12] = 0x00100 -> 0x00100000.
  - 0xFFF00 -> 0xFFF00000.
  - Check: rd bits set to 11111 do not change either result.
- Illegal:
  - immsrc 101/110/111 with all-ones instr -> immext 0, illegal 1.
  - Sweep unused bits (rs1/rs2/funct3/rd fields) randomly for each legal format; immext must be unchanged.
- Register:
  - rst_n low asynchronously mid-cycle -> immext_q 0, illegal_q 0 without waiting for a clock edge.
  - After release, with en = 1 and the I-type 0xFFC input -> immext_q = 0xFFFFFFFC one edge later.
  - en = 0 while the input changes -> immext_q holds.
